// File: rtl/rv32_mem_access.sv
// rv32_mem_access: RV32 memory-access pipeline stage.
// Issues at most one bus transaction at a time for loads and stores, aligns
// store data onto byte lanes, extracts and extends load data, and registers
// the writeback record (valid, rd, rd_write, rd_value, misaligned).
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   stall_in                hazard-unit stall (ignored while a transfer waits)
//   valid_in .. rs2_value_in  execute-stage instruction record
//   bus_*_out / bus_*_in    simple ready-handshaked memory bus
//   stall_out               freeze request while a transfer waits
//   valid_out .. rd_value_out  registered writeback record
module rv32_mem_access (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_in,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_fence_in,
    input  logic        mem_zero_extend_in,
    input  logic        rd_write_in,
    input  logic [1:0]  mem_width_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [31:0] bus_address_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic        rd_write_out,
    output logic        misaligned_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rd_value_out
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned MASKW = 4;
    localparam int unsigned REGW  = 5;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state;
    logic [XLEN-1:0]    lat_addr;
    logic [MASKW-1:0]   lat_mask;
    logic [XLEN-1:0]    lat_wdata;
    logic [1:0]         lat_width;
    logic               lat_zext;
    logic               lat_read;
    logic               lat_write;
    logic [REGW-1:0]    lat_rd;
    logic               lat_rd_write;

    logic access_c;
    logic misaligned_c;
    logic issue_c;

    // Byte enables for a store of the given width at the given byte lane.
    function automatic logic [MASKW-1:0] lane_mask(input logic [1:0] width, input logic [1:0] lane);
        case (width)
            2'd0:    lane_mask = MASKW'(4'b0001 << lane);
            2'd1:    lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Store data replicated so every lane the mask may select carries it.
    function automatic logic [XLEN-1:0] lane_data(input logic [1:0] width, input logic [XLEN-1:0] data);
        case (width)
            2'd0:    lane_data = {4{data[7:0]}};
            2'd1:    lane_data = {2{data[15:0]}};
            default: lane_data = data;
        endcase
    endfunction

    // Pick the addressed lane out of the bus word and extend it.
    function automatic logic [XLEN-1:0] load_extract(input logic [1:0] width, input logic zext,
                                                     input logic [1:0] lane, input logic [XLEN-1:0] data);
        logic [XLEN-1:0] sh;
        sh = data >> {lane, 3'b000};
        case (width)
            2'd0:    load_extract = zext ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    load_extract = zext ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extract = data;
        endcase
    endfunction

    // Decode of the instruction currently presented by execute.
    always_comb begin
        access_c     = valid_in & ~mem_fence_in & (mem_read_in | mem_write_in);
        misaligned_c = access_c & (((mem_width_in == 2'd1) & result_in[0]) |
                                   (mem_width_in[1] & (result_in[1:0] != 2'b00)));
        issue_c      = (state == S_IDLE) & access_c & ~misaligned_c & ~stall_in;
    end

    // Bus request and stall: live inputs in IDLE, latched copies in WAIT.
    always_comb begin
        bus_read_out        = 1'b0;
        bus_write_out       = 1'b0;
        bus_address_out     = '0;
        bus_write_mask_out  = '0;
        bus_write_value_out = '0;
        stall_out           = 1'b0;
        if (reset_n) begin
            if (state == S_WAIT) begin
                bus_read_out    = lat_read;
                bus_write_out   = lat_write;
                bus_address_out = {lat_addr[XLEN-1:2], 2'b00};
                if (lat_write) begin
                    bus_write_mask_out  = lat_mask;
                    bus_write_value_out = lat_wdata;
                end
                stall_out = ~bus_ready_in;
            end else if (issue_c) begin
                bus_read_out    = mem_read_in;
                bus_write_out   = ~mem_read_in;
                bus_address_out = {result_in[XLEN-1:2], 2'b00};
                if (!mem_read_in) begin
                    bus_write_mask_out  = lane_mask(mem_width_in, result_in[1:0]);
                    bus_write_value_out = lane_data(mem_width_in, rs2_value_in);
                end
            end
        end
    end

    // State, request latches and writeback registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            lat_addr       <= '0;
            lat_mask       <= '0;
            lat_wdata      <= '0;
            lat_width      <= '0;
            lat_zext       <= 1'b0;
            lat_read       <= 1'b0;
            lat_write      <= 1'b0;
            lat_rd         <= '0;
            lat_rd_write   <= 1'b0;
            valid_out      <= 1'b0;
            rd_write_out   <= 1'b0;
            misaligned_out <= 1'b0;
            rd_out         <= '0;
            rd_value_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!stall_in) begin
                        if (issue_c && !bus_ready_in) begin
                            // Writeback waits for the completing edge.
                            state        <= S_WAIT;
                            lat_addr     <= result_in;
                            lat_mask     <= lane_mask(mem_width_in, result_in[1:0]);
                            lat_wdata    <= lane_data(mem_width_in, rs2_value_in);
                            lat_width    <= mem_width_in;
                            lat_zext     <= mem_zero_extend_in;
                            lat_read     <= mem_read_in;
                            lat_write    <= ~mem_read_in;
                            lat_rd       <= rd_in;
                            lat_rd_write <= rd_write_in;
                        end else begin
                            valid_out      <= valid_in;
                            rd_out         <= rd_in;
                            rd_value_out   <= (issue_c && mem_read_in)
                                              ? load_extract(mem_width_in, mem_zero_extend_in,
                                                             result_in[1:0], bus_read_value_in)
                                              : result_in;
                            rd_write_out   <= rd_write_in & ~misaligned_c;
                            misaligned_out <= misaligned_c;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus_ready_in) begin
                        state          <= S_IDLE;
                        valid_out      <= 1'b1;
                        rd_out         <= lat_rd;
                        rd_value_out   <= lat_read
                                          ? load_extract(lat_width, lat_zext, lat_addr[1:0], bus_read_value_in)
                                          : lat_addr;
                        rd_write_out   <= lat_rd_write;
                        misaligned_out <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_access.sv
// Self-checking bench for rv32_mem_access: directed table, hand sequences for
// stall/reset/back-to-back corners, and randomized instructions checked
// against an arithmetic reference model.
module tb_rv32_mem_access;

    logic        clk;
    logic        reset_n;
    logic        stall_in;
    logic        valid_in, mem_read_in, mem_write_in, mem_fence_in, mem_zero_extend_in, rd_write_in;
    logic [1:0]  mem_width_in;
    logic [4:0]  rd_in;
    logic [31:0] result_in, rs2_value_in;
    logic        bus_read_out, bus_write_out;
    logic [31:0] bus_address_out;
    logic [3:0]  bus_write_mask_out;
    logic [31:0] bus_write_value_out;
    logic [31:0] bus_read_value_in;
    logic        bus_ready_in;
    logic        stall_out, valid_out, rd_write_out, misaligned_out;
    logic [4:0]  rd_out;
    logic [31:0] rd_value_out;

    rv32_mem_access dut (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in),
        .valid_in(valid_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_fence_in(mem_fence_in), .mem_zero_extend_in(mem_zero_extend_in),
        .rd_write_in(rd_write_in), .mem_width_in(mem_width_in), .rd_in(rd_in),
        .result_in(result_in), .rs2_value_in(rs2_value_in),
        .bus_read_out(bus_read_out), .bus_write_out(bus_write_out),
        .bus_address_out(bus_address_out), .bus_write_mask_out(bus_write_mask_out),
        .bus_write_value_out(bus_write_value_out), .bus_read_value_in(bus_read_value_in),
        .bus_ready_in(bus_ready_in), .stall_out(stall_out), .valid_out(valid_out),
        .rd_write_out(rd_write_out), .misaligned_out(misaligned_out),
        .rd_out(rd_out), .rd_value_out(rd_value_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rd, wr, fence, zext, rdw;
        logic [1:0]  w;
        logic [4:0]  rdn;
        logic [31:0] addr, rs2, rdata;
        int          waits;
        logic        e_brd, e_bwr, e_val, e_rdw, e_mis;
        logic [31:0] e_addr, e_wval, e_rdval;
        logic [3:0]  e_mask;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        prev_val;
    logic [31:0] prev_rdval;
    vec_t        tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t tv(input logic valid, rd, wr, fence, input logic [1:0] w, input logic zext,
                                input logic rdw, input logic [4:0] rdn, input logic [31:0] addr, rs2, rdata,
                                input int waits, input logic e_brd, e_bwr, input logic [31:0] e_addr,
                                input logic [3:0] e_mask, input logic [31:0] e_wval,
                                input logic e_val, e_rdw, e_mis, input logic [31:0] e_rdval);
        vec_t v;
        v.valid = valid; v.rd = rd; v.wr = wr; v.fence = fence; v.w = w; v.zext = zext;
        v.rdw = rdw; v.rdn = rdn; v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.waits = waits;
        v.e_brd = e_brd; v.e_bwr = e_bwr; v.e_addr = e_addr; v.e_mask = e_mask; v.e_wval = e_wval;
        v.e_val = e_val; v.e_rdw = e_rdw; v.e_mis = e_mis; v.e_rdval = e_rdval;
        return v;
    endfunction

    // Reference model: expected bus request and writeback from the access rules.
    function automatic vec_t model(input vec_t v);
        int          sz;
        bit          access, mis, req, isrd, iswr;
        logic [31:0] ones, ld;
        access = v.valid && !v.fence && (v.rd || v.wr);
        sz     = (v.w == 2'd0) ? 1 : (v.w == 2'd1) ? 2 : 4;
        mis    = access && ((v.addr % 32'(sz)) != 0);
        req    = access && !mis;
        isrd   = v.rd;
        iswr   = v.wr && !v.rd;
        v.e_brd  = req && isrd;
        v.e_bwr  = req && iswr;
        v.e_addr = req ? (v.addr & ~32'h3) : 32'h0;
        v.e_mask = (req && iswr) ? 4'(((1 << sz) - 1) << (v.addr % 4)) : 4'h0;
        if (!(req && iswr))  v.e_wval = 32'h0;
        else if (sz == 4)    v.e_wval = v.rs2;
        else if (sz == 2)    v.e_wval = (v.rs2 & 32'hFFFF) * 32'h0001_0001;
        else                 v.e_wval = (v.rs2 & 32'hFF) * 32'h0101_0101;
        if (sz == 4) ld = v.rdata;
        else begin
            ones = 32'((64'd1 << (8 * sz)) - 1);
            ld   = (v.rdata >> (8 * (v.addr % 4))) & ones;
            if (!v.zext && ld[8 * sz - 1]) ld = ld | ~ones;
        end
        v.e_rdval = (req && isrd) ? ld : v.addr;
        v.e_val   = v.valid;
        v.e_rdw   = v.rdw && !mis;
        v.e_mis   = mis;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        valid_in = v.valid; mem_read_in = v.rd; mem_write_in = v.wr; mem_fence_in = v.fence;
        mem_width_in = v.w; mem_zero_extend_in = v.zext; rd_write_in = v.rdw; rd_in = v.rdn;
        result_in = v.addr; rs2_value_in = v.rs2;
    endtask

    task automatic drive_idle();
        valid_in = 0; mem_read_in = 0; mem_write_in = 0; mem_fence_in = 0; mem_width_in = 0;
        mem_zero_extend_in = 0; rd_write_in = 0; rd_in = 0; result_in = 0; rs2_value_in = 0;
        stall_in = 0; bus_ready_in = 0; bus_read_value_in = 0;
    endtask

    task automatic chk_bus(input string tag, input vec_t v);
        chk({tag, "/bus_read"},  32'(bus_read_out),       32'(v.e_brd));
        chk({tag, "/bus_write"}, 32'(bus_write_out),      32'(v.e_bwr));
        chk({tag, "/bus_addr"},  bus_address_out,         v.e_addr);
        chk({tag, "/bus_mask"},  32'(bus_write_mask_out), 32'(v.e_mask));
        chk({tag, "/bus_wval"},  bus_write_value_out,     v.e_wval);
    endtask

    // One instruction: issue cycle, v.waits stall cycles, then completion.
    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        stall_in          = 1'b0;
        bus_ready_in      = (v.waits == 0);
        bus_read_value_in = (v.waits == 0) ? v.rdata : $urandom;
        #2;
        chk_bus(tag, v);
        chk({tag, "/stall_issue"}, 32'(stall_out), 32'd0);
        if (v.waits > 0) begin
            for (int i = 0; i <= v.waits; i++) begin
                @(negedge clk);
                // Execute-stage inputs must not disturb the waiting transfer.
                valid_in = 1'($urandom); mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
                mem_width_in = 2'($urandom); rd_in = 5'($urandom); result_in = $urandom;
                rs2_value_in = $urandom; stall_in = 1'($urandom); rd_write_in = 1'($urandom);
                bus_ready_in      = (i == v.waits);
                bus_read_value_in = bus_ready_in ? v.rdata : $urandom;
                #2;
                chk_bus({tag, "/wait"}, v);
                chk({tag, "/stall_wait"},  32'(stall_out),   32'(i != v.waits));
                chk({tag, "/hold_valid"},  32'(valid_out),   32'(prev_val));
                chk({tag, "/hold_rdval"},  rd_value_out,     prev_rdval);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "/valid_out"},   32'(valid_out),      32'(v.e_val));
        chk({tag, "/rd_out"},      32'(rd_out),         32'(v.rdn));
        chk({tag, "/rd_write"},    32'(rd_write_out),   32'(v.e_rdw));
        chk({tag, "/misaligned"},  32'(misaligned_out), 32'(v.e_mis));
        chk({tag, "/rd_value"},    rd_value_out,        v.e_rdval);
        prev_val   = v.e_val;
        prev_rdval = v.e_rdval;
    endtask

    initial begin
        vec_t v;
        int   reads;
        vec_t seq[3];

        // valid rd wr fence w zext rdw rdn addr rs2 rdata waits | brd bwr addr mask wval val rdw mis rdval
        tbl[0]  = tv(1,1,0,0,2'd0,0,1,5'd1, 32'h1003,0,32'h80FF_FFFF,0, 1,0,32'h1000,4'h0,0, 1,1,0,32'hFFFF_FF80);
        tbl[1]  = tv(1,1,0,0,2'd0,1,1,5'd2, 32'h1003,0,32'h80FF_FFFF,0, 1,0,32'h1000,4'h0,0, 1,1,0,32'h0000_0080);
        tbl[2]  = tv(1,1,0,0,2'd1,0,1,5'd3, 32'h2002,0,32'h8001_1234,0, 1,0,32'h2000,4'h0,0, 1,1,0,32'hFFFF_8001);
        tbl[3]  = tv(1,1,0,0,2'd1,1,1,5'd4, 32'h2000,0,32'h1234_ABCD,0, 1,0,32'h2000,4'h0,0, 1,1,0,32'h0000_ABCD);
        tbl[4]  = tv(1,1,0,0,2'd2,0,1,5'd5, 32'h0010,0,32'hCAFE_F00D,2, 1,0,32'h0010,4'h0,0, 1,1,0,32'hCAFE_F00D);
        tbl[5]  = tv(1,1,0,0,2'd0,0,1,5'd6, 32'h5001,0,32'h1122_3344,1, 1,0,32'h5000,4'h0,0, 1,1,0,32'h0000_0033);
        tbl[6]  = tv(1,0,1,0,2'd0,0,0,5'd0, 32'h4001,32'h1234_5678,0,0, 0,1,32'h4000,4'b0010,32'h7878_7878, 1,0,0,32'h4001);
        tbl[7]  = tv(1,0,1,0,2'd1,0,0,5'd0, 32'h2002,32'h0000_BEEF,0,3, 0,1,32'h2000,4'b1100,32'hBEEF_BEEF, 1,0,0,32'h2002);
        tbl[8]  = tv(1,0,1,0,2'd3,0,0,5'd0, 32'h0008,32'hA5A5_0F0F,0,0, 0,1,32'h0008,4'b1111,32'hA5A5_0F0F, 1,0,0,32'h0008);
        tbl[9]  = tv(1,1,0,0,2'd2,0,1,5'd7, 32'h3001,0,32'h5555_5555,0, 0,0,32'h0,4'h0,0, 1,0,1,32'h3001);
        tbl[10] = tv(1,1,0,0,2'd1,0,1,5'd8, 32'h3003,0,32'h5555_5555,0, 0,0,32'h0,4'h0,0, 1,0,1,32'h3003);
        tbl[11] = tv(1,0,0,0,2'd0,0,1,5'd9, 32'h1234,0,0,0,             0,0,32'h0,4'h0,0, 1,1,0,32'h1234);
        tbl[12] = tv(1,1,0,1,2'd2,0,0,5'd0, 32'h0040,0,32'h7777_7777,0, 0,0,32'h0,4'h0,0, 1,0,0,32'h0040);
        tbl[13] = tv(0,1,0,0,2'd2,0,0,5'd10,32'h0050,0,32'h6666_6666,0, 0,0,32'h0,4'h0,0, 0,0,0,32'h0050);
        tbl[14] = tv(1,1,1,0,2'd2,0,1,5'd11,32'h0020,32'hFFFF_FFFF,32'h0102_0304,0, 1,0,32'h0020,4'h0,0, 1,1,0,32'h0102_0304);

        // Reset with an access pending at the inputs.
        drive_idle();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        valid_in = 1; mem_read_in = 1; mem_width_in = 2'd2; result_in = 32'h100; bus_ready_in = 1;
        #1;
        chk("rst/bus_read",  32'(bus_read_out),       0);
        chk("rst/bus_write", 32'(bus_write_out),      0);
        chk("rst/bus_mask",  32'(bus_write_mask_out), 0);
        chk("rst/stall",     32'(stall_out),          0);
        @(posedge clk); #1;
        chk("rst/valid_out", 32'(valid_out),      0);
        chk("rst/rd_out",    32'(rd_out),         0);
        chk("rst/rd_value",  rd_value_out,        0);
        chk("rst/rd_write",  32'(rd_write_out),   0);
        chk("rst/misalign",  32'(misaligned_out), 0);
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
        prev_val = 0; prev_rdval = 0;

        for (int i = 0; i < 15; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        // stall_in in IDLE holds outputs and suppresses the request.
        apply_vec(tv(1,0,0,0,2'd0,0,1,5'd7,32'h77,0,0,0, 0,0,0,0,0, 1,1,0,32'h77), "pre_stall");
        @(negedge clk);
        valid_in = 1; mem_read_in = 1; mem_write_in = 0; mem_width_in = 2'd2; result_in = 32'h500;
        rd_in = 5'd9; rd_write_in = 1; stall_in = 1; bus_ready_in = 1; bus_read_value_in = 32'h55AA_55AA;
        #2;
        chk("stall/bus_read", 32'(bus_read_out), 0);
        @(posedge clk); #1;
        chk("stall/hold_rd",    32'(rd_out),  7);
        chk("stall/hold_rdval", rd_value_out, 32'h77);
        @(negedge clk);
        stall_in = 0;
        #2;
        chk("stall/bus_read_rel", 32'(bus_read_out), 1);
        chk("stall/bus_addr_rel", bus_address_out,   32'h500);
        @(posedge clk); #1;
        chk("stall/rd_rel",    32'(rd_out),  9);
        chk("stall/rdval_rel", rd_value_out, 32'h55AA_55AA);

        // Reset while a transfer waits abandons it.
        @(negedge clk);
        result_in = 32'h600; bus_ready_in = 0;
        #2;
        chk("rstwait/bus_read_issue", 32'(bus_read_out), 1);
        @(negedge clk); #2;
        chk("rstwait/stall_before", 32'(stall_out), 1);
        reset_n = 1'b0;
        #1;
        chk("rstwait/stall",     32'(stall_out),     0);
        chk("rstwait/bus_read",  32'(bus_read_out),  0);
        chk("rstwait/valid_out", 32'(valid_out),     0);
        @(negedge clk);
        reset_n = 1'b1; valid_in = 0;
        #2;
        chk("rstwait/bus_read_after", 32'(bus_read_out), 0);
        chk("rstwait/stall_after",    32'(stall_out),    0);
        @(posedge clk); #1;
        chk("rstwait/valid_after", 32'(valid_out), 0);
        prev_val = 0; prev_rdval = 32'h600;

        // add, lw, fence back to back.
        seq[0] = tv(1,0,0,0,2'd0,0,1,5'd1,32'h000A,0,0,0,             0,0,0,0,0, 1,1,0,32'h000A);
        seq[1] = tv(1,1,0,0,2'd2,0,1,5'd2,32'h0010,0,32'h1234_5678,0, 1,0,32'h10,0,0, 1,1,0,32'h1234_5678);
        seq[2] = tv(1,0,0,1,2'd0,0,0,5'd0,32'h0000,0,0,0,             0,0,0,0,0, 1,0,0,32'h0);
        reads = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(seq[i]); stall_in = 0; bus_ready_in = 1; bus_read_value_in = seq[i].rdata;
            #2;
            if (bus_read_out) reads++;
            @(posedge clk); #1;
            chk($sformatf("b2b%0d/valid_out", i), 32'(valid_out), 1);
            chk($sformatf("b2b%0d/rd_value", i),  rd_value_out,   seq[i].e_rdval);
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        chk("b2b/valid_drop", 32'(valid_out), 0);
        chk("b2b/bus_reads",  32'(reads),     1);
        prev_val = 0; prev_rdval = 0;

        // Randomized instructions against the model.
        for (int n = 0; n < 300; n++) begin
            int op;
            op      = int'($urandom % 4);
            v.valid = ($urandom % 8) != 0;
            v.rd    = (op == 0) || (op == 2);
            v.wr    = (op == 1) || (op == 2);
            v.fence = ($urandom % 10) == 0;
            v.w     = 2'($urandom);
            v.zext  = 1'($urandom);
            v.rdw   = 1'($urandom);
            v.rdn   = 5'($urandom);
            v.addr  = $urandom;
            v.rs2   = $urandom;
            v.rdata = $urandom;
            v       = model(v);
            v.waits = (v.e_brd || v.e_bwr) ? int'($urandom % 4) : 0;
            apply_vec(v, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_mem_access.md
RV32_MEM_ACCESS -- requirements
Module: rv32_mem_access

Interface
Parameters: none.
REQ-001 The block SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- stall_in  in  1  hazard unit stall
- valid_in, mem_read_in, mem_write_in, mem_fence_in, mem_zero_extend_in, rd_write_in  in  1 each  execute-stage control
- mem_width_in  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- rd_in  in  5  destination register
- result_in  in  32  ALU result / effective address
- rs2_value_in  in  32  store data
- bus_read_out, bus_write_out  out  1 each  bus request strobes
- bus_address_out  out  32  word-aligned address, bits [1:0] always 0
- bus_write_mask_out  out  4  byte enables
- bus_write_value_out  out  32  lane-aligned store data
- bus_read_value_in  in  32  load data
- bus_ready_in  in  1  transfer completes this cycle
- stall_out  out  1  request to hazard unit to freeze earlier stages
- valid_out, rd_write_out, misaligned_out  out  1 each  writeback control
- rd_out  out  5; rd_value_out  out  32  writeback data

Function
REQ-002 Access = valid_in & (mem_read_in | mem_write_in); mem_read_in takes priority if both are set.
REQ-003 Misaligned = half with address[0]=1, or word with address[1:0]!=0; a misaligned access SHALL issue no bus request.
REQ-004 FSM states: IDLE and WAIT. Reset state is IDLE.
REQ-005 IDLE, with an aligned access and !stall_in: drive the bus request combinationally this cycle. If bus_ready_in=1, complete in zero wait cycles and stay in IDLE. Otherwise latch address, mask, data, width, extend, rd and rd_write, and enter WAIT.
REQ-006 WAIT: drive the bus request from the latched copies, held stable. Assert stall_out combinationally. Return to IDLE in the cycle bus_ready_in=1, deasserting stall_out that cycle.
REQ-007 stall_out SHALL be 0 in IDLE.
REQ-008 Bus outputs SHALL be 0 whenever no request is driven.
REQ-009 Output registers SHALL update only on edges where stall_in=0 and stall_out=0, and hold otherwise.
- In WAIT they update on the completing edge.
- stall_in is ignored while in WAIT.
REQ-010 Store lanes:
- byte: data[7:0] replicated to all 4 lanes, mask = 1<<addr[1:0]
- half: data[15:0] replicated to both halves, mask = 0011 or 1100 by addr[1]
- word: mask = 1111
REQ-011 Load: select the lane by addr[1:0]; sign-extend, or zero-extend when mem_zero_extend_in=1. Word loads are passed through unchanged.
REQ-012 On an update edge:
- valid_out <= valid_in; rd_out <= rd_in.
- rd_value_out <= load data for reads, otherwise result_in.
- rd_write_out <= rd_write_in & !misaligned.
- misaligned_out <= access & misaligned.
REQ-013 A fence or non-memory instruction SHALL pass through in one cycle with no bus request; only one bus transaction is ever outstanding.
REQ-014 When valid_in=0, no bus request SHALL be issued and valid_out <= 0 on the update edge.

Reset
REQ-015 When reset_n=0, asynchronously:
- state <= IDLE
- valid_out, rd_write_out, misaligned_out <= 0
- rd_out <= 0; rd_value_out <= 0
- all latched request registers <= 0
REQ-016 While reset_n=0, the bus strobes, bus_write_mask_out and stall_out SHALL read 0.
REQ-017 Reset asserted in WAIT SHALL abandon the transaction; the block then resumes in IDLE with no bus request.

Verification
REQ-018 Zero-wait load: lb, addr 0x1003, bus_read_value_in 0x80FFFFFF, ready=1 -> bus_address_out 0x1000, no stall; next edge rd_value_out 0xFFFFFF80. With lbu the result is 0x00000080.
REQ-019 Wait-state store: sh, addr 0x2002, rs2 0x0000BEEF, ready held low 3 cycles -> stall_out high for 3 cycles; mask 1100; value 0xBEEFBEEF held stable throughout; single completion.
REQ-020 Misaligned: lw, addr 0x3001 -> no bus strobe, misaligned_out=1, rd_write_out=0, valid_out=1.
REQ-021 stall_in=1 in IDLE with a pending access -> no bus strobe, outputs hold; request issues the cycle stall_in falls.
REQ-022 Reset asserted during WAIT -> immediately state IDLE, stall_out=0, strobes 0, valid_out=0.
REQ-023 Back-to-back: add, then lw at 0x10 with ready=1, then fence -> three valid_out pulses on consecutive edges; exactly one bus read.
